rca_word_sequencer: RTL

Multi-cycle sequencer that adds or subtracts wide operands by reusing one 4-bit ripple_carry_adder slice once per clock. It latches an operation through a valid/ready input handshake and walks the operand slices LSB-first, chaining the carry through a register. It presents the result, carry and signed overflow through a valid/ready output handshake. Used wherever a wide add is needed and area matters more than latency.

---
 rtl/rca_word_sequencer.sv | 110 +++++++++++
 1 files changed

// File: rtl/rca_word_sequencer.sv
// rca_word_sequencer: wide add/subtract built from one 4-bit ripple-carry slice reused once per clock
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   in_valid, in_ready  operation request handshake; A, B, Cin, sub are captured on accept
//   A, B                W-bit operands (W = 4*NSLICE)
//   Cin                 carry in, used only for add
//   sub                 1: A - B, 0: A + B + Cin
//   out_valid, out_ready result handshake
//   S, C, V             result, carry out of bit W-1 (1 = no borrow on sub), signed overflow
//   busy                high while an operation is running or waiting for handoff

module ripple_carry_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [4:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign cout = c[4];
endmodule

module rca_word_sequencer #(
    parameter int NSLICE = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*NSLICE-1:0]   A,
    input  logic [4*NSLICE-1:0]   B,
    input  logic                  Cin,
    input  logic                  sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*NSLICE-1:0]   S,
    output logic                  C,
    output logic                  V,
    output logic                  busy
);
    localparam int KW = NSLICE > 1 ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_next;

    logic [NSLICE-1:0][3:0] a_reg, b_reg, s_reg;
    logic [KW-1:0]          k;
    logic                   carry;
    logic [3:0]             sum;
    logic                   cout;
    logic                   last;

    ripple_carry_adder u_slice (
        .a   (a_reg[k]),
        .b   (b_reg[k]),
        .cin (carry),
        .s   (sum),
        .cout(cout)
    );

    assign last = k == KW'(NSLICE - 1);
    assign S    = s_reg;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = state == IDLE;
        busy       = state != IDLE;
        out_valid  = state == DONE;
        state_next = (state == IDLE && in_valid)  ? RUN  :
                     (state == RUN  && last)      ? DONE :
                     (state == DONE && out_ready) ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg <= '0;
            b_reg <= '0;
            s_reg <= '0;
            carry <= 1'b0;
            k     <= '0;
            C     <= 1'b0;
            V     <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            // subtraction is A + ~B + 1, so the inverted operand and forced carry are stored up front
            a_reg <= A;
            b_reg <= sub ? ~B : B;
            carry <= sub ? 1'b1 : Cin;
            k     <= '0;
            s_reg <= '0;
        end else if (state == RUN) begin
            s_reg[k] <= sum;
            carry    <= cout;
            k        <= last ? k : k + KW'(1);
            if (last) begin
                C <= cout;
                V <= (a_reg[NSLICE-1][3] == b_reg[NSLICE-1][3]) && (sum[3] != a_reg[NSLICE-1][3]);
            end
        end
    end
endmodule
